// File: rtl/mf8_ifetch.sv
// mf8 instruction-fetch front end: reads the word at PC over a Req/Ack handshake,
// hands it to the decoder through a one-entry skid and paces the PC sequencer via Pause.
module mf8_ifetch #(
  parameter int unsigned   AW       = 12,
  parameter int unsigned   DW       = 16,
  parameter logic [DW-1:0] RST_INST = {DW{1'b0}}
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [AW-1:0] NPC,
  input  logic          RJmp,
  input  logic          Stall,
  output logic          Pause,
  output logic          Mem_Req,
  output logic [AW-1:0] Mem_Addr,
  input  logic          Mem_Ack,
  input  logic [DW-1:0] Mem_Data,
  output logic [DW-1:0] Inst,
  output logic          Inst_Valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] addr_nx;
  logic [AW-1:0] flush_tgt;
  logic [AW-1:0] tgt_nx;
  logic [DW-1:0] skid_word;
  logic [DW-1:0] skid_nx;
  logic [DW-1:0] inst_nx;
  logic          valid_nx;
  logic          accept;

  // A word is accepted only when it reaches Inst; only then may the PC advance.
  assign accept  = ~RJmp & ~Stall & (((state == FETCH) & Mem_Ack) | (state == HOLD));
  assign Pause   = ~accept;
  assign Mem_Req = (state == FETCH) | (state == FLUSH);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      Mem_Addr   <= '0;
      flush_tgt  <= '0;
      skid_word  <= '0;
      Inst       <= RST_INST;
      Inst_Valid <= 1'b0;
    end else begin
      state      <= state_nx;
      Mem_Addr   <= addr_nx;
      flush_tgt  <= tgt_nx;
      skid_word  <= skid_nx;
      Inst       <= inst_nx;
      Inst_Valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = Mem_Addr;
    tgt_nx   = flush_tgt;
    skid_nx  = skid_word;
    inst_nx  = Inst;
    valid_nx = Inst_Valid;

    case (state)
      IDLE: begin
        addr_nx  = NPC;
        state_nx = FETCH;
      end

      FETCH: begin
        if (RJmp) begin
          valid_nx = 1'b0;
          if (Mem_Ack) begin
            addr_nx = NPC;
          end else begin
            // The stale request must complete before the target can be issued.
            tgt_nx   = NPC;
            state_nx = FLUSH;
          end
        end else if (Mem_Ack) begin
          if (Stall) begin
            skid_nx  = Mem_Data;
            state_nx = HOLD;
          end else begin
            inst_nx  = Mem_Data;
            valid_nx = 1'b1;
            addr_nx  = NPC;
          end
        end else if (!Stall) begin
          valid_nx = 1'b0;
        end
      end

      HOLD: begin
        if (RJmp) begin
          valid_nx = 1'b0;
          addr_nx  = NPC;
          state_nx = FETCH;
        end else if (!Stall) begin
          inst_nx  = skid_word;
          valid_nx = 1'b1;
          addr_nx  = NPC;
          state_nx = FETCH;
        end
      end

      FLUSH: begin
        if (RJmp) begin
          valid_nx = 1'b0;
          tgt_nx   = NPC;
          if (Mem_Ack) begin
            addr_nx  = NPC;
            state_nx = FETCH;
          end
        end else begin
          if (!Stall) valid_nx = 1'b0;
          if (Mem_Ack) begin
            addr_nx  = flush_tgt;
            state_nx = FETCH;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
